// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl: Wishbone slave with an internal byte-laned BRAM and a run-time programmable wait state count.
//
// Ports:
//   wb_clk_i    - clock, rising edge
//   wb_rst_n_i  - asynchronous active-low reset
//   wbs_cyc_i   - Wishbone cycle
//   wbs_stb_i   - Wishbone strobe
//   wbs_we_i    - 1 = write
//   wbs_sel_i   - byte lane selects (memory window only)
//   wbs_adr_i   - byte address; [31:20] = BASE_ADDR, [19] = 0 memory / 1 CSR
//   wbs_dat_i   - write data
//   wbs_ack_o   - single-cycle acknowledge
//   wbs_dat_o   - registered read data, held between acks
//   busy_o      - FSM not idle
//
// CSR window (offset = wbs_adr_i[3:2]): 0 DELAY, 1 ACCESS_CNT, 2 ERR_CNT, 3 reserved.
// Define WB_BRAM_CTRL_STATS_EN to build the ACCESS_CNT / ERR_CNT statistics counters.
module wb_bram_ctrl #(
    parameter logic [11:0] BASE_ADDR      = 12'h380,
    parameter int          DEPTH          = 1024,
    parameter int          DELAY_W        = 16,
    parameter int          DEFAULT_DELAYS = 10,
    parameter int          CNT_W          = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state_q, state_d;
    logic [DELAY_W-1:0]  delay_q, d_q, cnt_q;
    logic [17:0]         adr_q;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [31:0]         wdat_q, dat_q, csr_rd;
    logic                valid, oor, mem_done, unused_bits;
    logic [31:0]         mem [DEPTH];
`ifdef WB_BRAM_CTRL_STATS_EN
    logic [CNT_W-1:0]    acc_q, err_q;
`endif

    assign valid       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:20] == BASE_ADDR);
    // adr_q holds byte address bits [19:2]: [17] window, [16:0] word index
    assign oor         = 32'(adr_q[16:0]) >= 32'(DEPTH);
    assign mem_done    = (state_q == WAIT) && wbs_cyc_i && (cnt_q == d_q);
    assign unused_bits = ^{wbs_adr_i[1:0], adr_q[17]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // An abort (cyc dropped) takes priority over the wait counter reaching D
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = valid ? (wbs_adr_i[19] ? ACK : WAIT) : IDLE;
            WAIT:    state_d = !wbs_cyc_i ? IDLE : (cnt_q == d_q) ? ACK : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (state_q == ACK);
        busy_o    = (state_q != IDLE);
        wbs_dat_o = dat_q;
    end

    always_comb begin
        csr_rd = '0;
        case (wbs_adr_i[3:2])
            2'd0:    csr_rd = 32'(delay_q);
`ifdef WB_BRAM_CTRL_STATS_EN
            2'd1:    csr_rd = 32'(acc_q);
            2'd2:    csr_rd = 32'(err_q);
`endif
            default: csr_rd = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            delay_q <= DELAY_W'(DEFAULT_DELAYS);
            d_q     <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            dat_q   <= '0;
`ifdef WB_BRAM_CTRL_STATS_EN
            acc_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            if (state_q == IDLE && valid) begin
                adr_q  <= wbs_adr_i[19:2];
                we_q   <= wbs_we_i;
                sel_q  <= wbs_sel_i;
                wdat_q <= wbs_dat_i;
                d_q    <= delay_q;
                cnt_q  <= '0;
                // CSR accesses complete here: whole-register write or read capture
                if (wbs_adr_i[19]) begin
                    if (!wbs_we_i)
                        dat_q <= csr_rd;
                    else if (|wbs_sel_i && wbs_adr_i[3:2] == 2'd0)
                        delay_q <= wbs_dat_i[DELAY_W-1:0];
`ifdef WB_BRAM_CTRL_STATS_EN
                    if (wbs_we_i && |wbs_sel_i && wbs_adr_i[3:2] == 2'd2)
                        err_q <= '0;
`endif
                end
            end
            if (state_q == WAIT)
                cnt_q <= cnt_q + 1'b1;
            if (mem_done && !we_q)
                dat_q <= oor ? '0 : mem[adr_q[AW-1:0]];
`ifdef WB_BRAM_CTRL_STATS_EN
            if (state_q == ACK && !adr_q[17]) begin
                acc_q <= acc_q + 1'b1;
                if (oor && err_q != '1)
                    err_q <= err_q + 1'b1;
            end
`endif
        end
    end

    // Storage has no reset; mem_done is false while reset holds the FSM in IDLE
    always_ff @(posedge wb_clk_i) begin
        if (mem_done && we_q && !oor)
            for (int b = 0; b < 4; b++)
                if (sel_q[b])
                    mem[adr_q[AW-1:0]][8*b +: 8] <= wdat_q[8*b +: 8];
    end
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// tb_wb_bram_ctrl: directed self-checking bench for wb_bram_ctrl with a read-data scoreboard.
module tb_wb_bram_ctrl;
    logic        clk, rst_n, cyc, stb, we, ack, busy;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic [31:0] exp_q[$];
    int          tests, fails;

`ifdef WB_BRAM_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    wb_bram_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; for reads d is the expected data and goes into the scoreboard.
    // lat = negedges from the request cycle to the ack cycle.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, input int lat);
        int n;
        if (!w) exp_q.push_back(d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = w ? d : 32'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, " busy"}, 32'(busy), 32'd1);
        end while (!ack && n < 40);
        check({tag, " latency"}, 32'(n), 32'(lat));
        if (!w) check({tag, " data"}, rdat, exp_q.pop_front());
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check({tag, " single ack"}, 32'(ack), 32'd0);
    endtask

    function automatic logic [31:0] st(input logic [31:0] v);
        return STATS ? v : 32'h0;
    endfunction

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(negedge clk);
        check("reset ack", 32'(ack), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset dat", rdat, 32'h0);
        rst_n = 1'b1;

        xfer("rd DELAY default", 32'h3808_0000, 1'b0, 4'hF, 32'd10, 1);
        xfer("wr DELAY 3", 32'h3808_0000, 1'b1, 4'hF, 32'd3, 1);
        xfer("rd DELAY 3", 32'h3808_0000, 1'b0, 4'hF, 32'd3, 1);
        xfer("wr 0x10 full", 32'h3800_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 5);
        xfer("rd 0x10 full", 32'h3800_0010, 1'b0, 4'hF, 32'hDEAD_BEEF, 5);
        xfer("wr 0x10 lanes", 32'h3800_0010, 1'b1, 4'b0101, 32'h1122_3344, 5);
        xfer("rd 0x10 lanes", 32'h3800_0010, 1'b0, 4'hF, 32'hDE22_BE44, 5);
        xfer("rd ACCESS 4", 32'h3808_0004, 1'b0, 4'hF, st(32'd4), 1);
        xfer("wr CSR3", 32'h3808_000C, 1'b1, 4'hF, 32'hFFFF_FFFF, 1);
        xfer("rd CSR3", 32'h3808_000C, 1'b0, 4'hF, 32'h0, 1);
        xfer("wr ACCESS ignored", 32'h3808_0004, 1'b1, 4'hF, 32'h1234_0000, 1);

        xfer("wr DELAY 0", 32'h3808_0000, 1'b1, 4'hF, 32'd0, 1);
        xfer("wr idx0", 32'h3800_0000, 1'b1, 4'hF, 32'h0102_0304, 2);
        xfer("rd oor", 32'h3800_1000, 1'b0, 4'hF, 32'h0, 2);
        xfer("rd ERR 1", 32'h3808_0008, 1'b0, 4'hF, st(32'd1), 1);
        xfer("rd ACCESS 6", 32'h3808_0004, 1'b0, 4'hF, st(32'd6), 1);
        xfer("wr oor", 32'h3800_1000, 1'b1, 4'hF, 32'hBAD0_BAD0, 2);
        xfer("rd idx0 intact", 32'h3800_0000, 1'b0, 4'hF, 32'h0102_0304, 2);
        xfer("rd ERR 2", 32'h3808_0008, 1'b0, 4'hF, st(32'd2), 1);
        xfer("wr ERR clear", 32'h3808_0008, 1'b1, 4'hF, 32'h5A5A_5A5A, 1);
        xfer("rd ERR 0", 32'h3808_0008, 1'b0, 4'hF, 32'h0, 1);

        xfer("wr DELAY 8", 32'h3808_0000, 1'b1, 4'hF, 32'd8, 1);
        xfer("wr 0x20 base", 32'h3800_0020, 1'b1, 4'hF, 32'h55AA_55AA, 10);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3800_0020; wdat = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no ack", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort ack stays low", 32'(ack), 32'd0);
        end
        check("abort idle", 32'(busy), 32'd0);
        xfer("rd 0x20 after abort", 32'h3800_0020, 1'b0, 4'hF, 32'h55AA_55AA, 10);
        xfer("rd ACCESS after abort", 32'h3808_0004, 1'b0, 4'hF, st(32'd10), 1);

        xfer("wr DELAY 6", 32'h3808_0000, 1'b1, 4'hF, 32'd6, 1);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3800_0020; wdat = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("mid-wait busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst ack", 32'(ack), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst dat", rdat, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer("rd DELAY after rst", 32'h3808_0000, 1'b0, 4'hF, 32'd10, 1);
        xfer("rd ACCESS after rst", 32'h3808_0004, 1'b0, 4'hF, 32'h0, 1);
        xfer("rd ERR after rst", 32'h3808_0008, 1'b0, 4'hF, 32'h0, 1);
        xfer("rd 0x20 after rst", 32'h3800_0020, 1'b0, 4'hF, 32'h55AA_55AA, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
